// File: rtl/sd_host.sv
// SD host CMD-line engine: serialises a 48-bit command frame with CRC7 and
// receives/validates the optional 48- or 136-bit response.
module sd_host (
  input  logic        clock,
  input  logic        reset,
  input  logic        sd_clock,
  input  logic        cmd_pin_in,
  output logic        cmd_pin_out,
  input  logic [31:0] R024h_CPU,
  input  logic [15:0] R00eh_CPU,
  input  logic [15:0] R008h_CPU,
  input  logic [15:0] R032h_CPU,
  output logic [31:0] R024h_CPU_out,
  output logic [15:0] R00eh_CPU_out,
  output logic [15:0] R008h_CPU_out,
  output logic [15:0] R032h_CPU_out
);

  typedef enum logic [2:0] {StIdle, StSend, StWait, StRecv, StDone} t_state;

  t_state         r_state;
  t_state         w_state_next;
  logic           r_sd_prev;
  logic           r_req_prev;
  logic   [7:0]   r_cnt;
  logic   [47:0]  r_tx;
  logic   [127:0] r_resp;
  logic   [15:0]  r_cmd;
  logic   [15:0]  r_arg;
  logic   [3:0]   r_err;
  logic           r_done;
  logic           r_cmd_out;

  logic           w_tick;
  logic           w_req_edge;
  logic           w_long;
  logic           w_rx_last;
  logic   [39:0]  w_frame40;
  logic   [47:0]  w_frame;
  logic   [127:0] w_resp_next;

  // CRC7, polynomial x^7 + x^3 + 1, MSB first, zero seed.
  function automatic logic [6:0] f_crc7(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign w_tick      = sd_clock & ~r_sd_prev;
  assign w_req_edge  = R024h_CPU[0] & ~r_req_prev;
  assign w_long      = (r_cmd[1:0] == 2'b01);
  assign w_rx_last   = w_long ? (r_cnt == 8'd134) : (r_cnt == 8'd46);
  assign w_frame40   = {2'b01, R00eh_CPU[13:8], 16'h0000, R008h_CPU};
  assign w_frame     = {w_frame40, f_crc7(w_frame40), 1'b1};
  assign w_resp_next = {r_resp[126:0], cmd_pin_in};

  assign cmd_pin_out   = r_cmd_out;
  assign R024h_CPU_out = {30'h0, r_done,
                          (r_state == StSend) | (r_state == StWait) | (r_state == StRecv)};
  assign R00eh_CPU_out = r_cmd;
  assign R008h_CPU_out = r_arg;
  assign R032h_CPU_out = {12'h000, r_err};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_req_edge) w_state_next = StSend;
      StSend: begin
        if (w_tick && r_cnt == 8'd48) begin
          w_state_next = (r_cmd[1:0] == 2'b00) ? StDone : StWait;
        end
      end
      StWait: begin
        if (w_tick) begin
          if (!cmd_pin_in)          w_state_next = StRecv;
          else if (r_cnt == 8'd63)  w_state_next = StDone;
        end
      end
      StRecv: if (w_tick && w_rx_last) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_sd_prev  <= 1'b0;
      r_req_prev <= 1'b0;
      r_cnt      <= 8'd0;
      r_tx       <= 48'h0;
      r_resp     <= 128'h0;
      r_cmd      <= 16'h0;
      r_arg      <= 16'h0;
      r_err      <= 4'h0;
      r_done     <= 1'b0;
      r_cmd_out  <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_sd_prev  <= sd_clock;
      r_req_prev <= R024h_CPU[0];
      unique case (r_state)
        StIdle: begin
          // A request edge takes priority over a simultaneous clear mask.
          if (w_req_edge) begin
            r_cmd  <= R00eh_CPU;
            r_err  <= 4'h0;
            r_done <= 1'b0;
            r_resp <= 128'h0;
            r_tx   <= w_frame;
            r_cnt  <= 8'd0;
          end else begin
            r_err <= r_err & ~R032h_CPU[3:0];
          end
        end
        StSend: begin
          if (w_tick) begin
            if (r_cnt == 8'd48) begin
              r_cmd_out <= 1'b1;
              r_cnt     <= 8'd0;
              if (r_cmd[1:0] == 2'b00) r_arg <= r_resp[15:0];
            end else begin
              r_cmd_out <= r_tx[47];
              r_tx      <= {r_tx[46:0], 1'b0};
              r_cnt     <= r_cnt + 8'd1;
            end
          end
        end
        StWait: begin
          if (w_tick) begin
            if (!cmd_pin_in) begin
              r_cnt <= 8'd0;
            end else if (r_cnt == 8'd63) begin
              r_err[0] <= 1'b1;
              r_arg    <= r_resp[15:0];
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        StRecv: begin
          if (w_tick) begin
            r_resp <= w_resp_next;
            r_cnt  <= r_cnt + 8'd1;
            if (w_rx_last) begin
              // The start bit is never shifted in; the cleared register supplies it as 0.
              if (!w_long) begin
                if (f_crc7(w_resp_next[47:8]) != w_resp_next[7:1]) r_err[1] <= 1'b1;
                if (w_resp_next[45:40] != r_cmd[13:8])            r_err[3] <= 1'b1;
                r_arg <= w_resp_next[23:8];
              end else begin
                r_arg <= w_resp_next[15:0];
              end
              if (!w_resp_next[0]) r_err[2] <= 1'b1;
            end
          end
        end
        StDone: r_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_host.sv
// Directed bench for sd_host: command framing, response checks, timeout,
// busy-request rejection, error clearing and mid-command reset.
module tb_sd_host;

  logic        clock;
  logic        reset;
  logic        sd_clock;
  logic        cmd_pin_in;
  logic        cmd_pin_out;
  logic [31:0] R024h_CPU;
  logic [15:0] R00eh_CPU;
  logic [15:0] R008h_CPU;
  logic [15:0] R032h_CPU;
  logic [31:0] R024h_CPU_out;
  logic [15:0] R00eh_CPU_out;
  logic [15:0] R008h_CPU_out;
  logic [15:0] R032h_CPU_out;

  int total = 0;
  int bad   = 0;

  sd_host dut (
    .clock         (clock),
    .reset         (reset),
    .sd_clock      (sd_clock),
    .cmd_pin_in    (cmd_pin_in),
    .cmd_pin_out   (cmd_pin_out),
    .R024h_CPU     (R024h_CPU),
    .R00eh_CPU     (R00eh_CPU),
    .R008h_CPU     (R008h_CPU),
    .R032h_CPU     (R032h_CPU),
    .R024h_CPU_out (R024h_CPU_out),
    .R00eh_CPU_out (R00eh_CPU_out),
    .R008h_CPU_out (R008h_CPU_out),
    .R032h_CPU_out (R032h_CPU_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // SD clock at a quarter of the system clock, changing away from the active edge.
  initial begin
    sd_clock = 1'b0;
    forever begin
      repeat (2) @(negedge clock);
      sd_clock = ~sd_clock;
    end
  end

  // CRC7 by polynomial long division (generator 0x89).
  function automatic logic [6:0] ref_crc7(input logic [39:0] data);
    logic [46:0] d;
    d = {data, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
    end
    return d[6:0];
  endfunction

  task automatic wait_tick();
    @(posedge sd_clock);
    @(posedge clock);
    #1;
  endtask

  task automatic start_cmd(input logic [15:0] cmd, input logic [15:0] arg);
    wait_tick();
    R00eh_CPU = cmd;
    R008h_CPU = arg;
    R024h_CPU = 32'h1;
    @(posedge clock);
    #1;
    R024h_CPU = 32'h0;
  endtask

  task automatic capture(output logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      wait_tick();
      f[i] = cmd_pin_out;
    end
  endtask

  task automatic reply(input logic [47:0] r);
    for (int i = 47; i >= 0; i--) begin
      cmd_pin_in = r[i];
      wait_tick();
    end
    cmd_pin_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic run_cmd8(input logic [47:0] r, output logic [47:0] f);
    start_cmd(16'h0802, 16'h01AA);
    capture(f);
    wait_tick();
    reply(r);
  endtask

  task automatic test_reset();
    total++;
    if (cmd_pin_out !== 1'b1) begin
      bad++; $display("FAIL reset_cmd_pin: got %b want 1", cmd_pin_out);
    end
    total++;
    if ({R024h_CPU_out, R00eh_CPU_out, R008h_CPU_out, R032h_CPU_out} !== 80'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h %h %h %h want all 0",
               R024h_CPU_out, R00eh_CPU_out, R008h_CPU_out, R032h_CPU_out);
    end
  endtask

  task automatic test_cmd0();
    logic [47:0] f;
    start_cmd(16'h0000, 16'h0000);
    total++;
    if (R024h_CPU_out !== 32'h1) begin
      bad++; $display("FAIL cmd0_busy: got %h want 00000001", R024h_CPU_out);
    end
    capture(f);
    total++;
    if (f !== 48'h400000000095) begin
      bad++; $display("FAIL cmd0_frame: got %h want 400000000095", f);
    end
    wait_tick();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (R024h_CPU_out !== 32'h2) begin
      bad++; $display("FAIL cmd0_status: got %h want 00000002", R024h_CPU_out);
    end
    total++;
    if (R032h_CPU_out !== 16'h0) begin
      bad++; $display("FAIL cmd0_err: got %h want 0000", R032h_CPU_out);
    end
  endtask

  task automatic test_cmd8_ok();
    logic [47:0] f;
    run_cmd8(48'h08000001AA13, f);
    total++;
    if (f !== 48'h48000001AA87) begin
      bad++; $display("FAIL cmd8_frame: got %h want 48000001AA87", f);
    end
    total++;
    if (R008h_CPU_out !== 16'h01AA) begin
      bad++; $display("FAIL cmd8_arg: got %h want 01AA", R008h_CPU_out);
    end
    total++;
    if (R032h_CPU_out !== 16'h0) begin
      bad++; $display("FAIL cmd8_err: got %h want 0000", R032h_CPU_out);
    end
    total++;
    if (R00eh_CPU_out !== 16'h0802) begin
      bad++; $display("FAIL cmd8_latched: got %h want 0802", R00eh_CPU_out);
    end
    total++;
    if (R024h_CPU_out !== 32'h2) begin
      bad++; $display("FAIL cmd8_status: got %h want 00000002", R024h_CPU_out);
    end
  endtask

  task automatic test_bad_response();
    logic [47:0] f;
    logic [47:0] r;
    run_cmd8(48'h08000001AA15, f);
    total++;
    if (R032h_CPU_out !== 16'h0002) begin
      bad++; $display("FAIL bad_crc: got %h want 0002", R032h_CPU_out);
    end
    r = {40'h09000001AA, ref_crc7(40'h09000001AA), 1'b1};
    run_cmd8(r, f);
    total++;
    if (R032h_CPU_out !== 16'h0008) begin
      bad++; $display("FAIL bad_index: got %h want 0008", R032h_CPU_out);
    end
    run_cmd8(48'h08000001AA12, f);
    total++;
    if (R032h_CPU_out !== 16'h0004) begin
      bad++; $display("FAIL bad_end: got %h want 0004", R032h_CPU_out);
    end
    total++;
    if (R024h_CPU_out !== 32'h2) begin
      bad++; $display("FAIL bad_status: got %h want 00000002", R024h_CPU_out);
    end
  endtask

  task automatic test_timeout_busy();
    logic [47:0] f;
    start_cmd(16'h0802, 16'h01AA);
    capture(f);
    wait_tick();
    for (int t = 0; t < 63; t++) begin
      wait_tick();
      if (t == 30) begin
        R00eh_CPU = 16'h1100;
        R024h_CPU = 32'h1;
        @(posedge clock);
        #1;
        R024h_CPU = 32'h0;
        R00eh_CPU = 16'h0802;
      end
    end
    total++;
    if (R024h_CPU_out !== 32'h1) begin
      bad++; $display("FAIL timeout_still_busy: got %h want 00000001", R024h_CPU_out);
    end
    total++;
    if (R00eh_CPU_out !== 16'h0802) begin
      bad++; $display("FAIL busy_req_ignored: got %h want 0802", R00eh_CPU_out);
    end
    wait_tick();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (R032h_CPU_out !== 16'h0001) begin
      bad++; $display("FAIL timeout_err: got %h want 0001", R032h_CPU_out);
    end
    total++;
    if (R024h_CPU_out !== 32'h2) begin
      bad++; $display("FAIL timeout_status: got %h want 00000002", R024h_CPU_out);
    end
  endtask

  task automatic test_clear();
    R032h_CPU = 16'hFFFF;
    @(posedge clock);
    #1;
    R032h_CPU = 16'h0000;
    total++;
    if (R032h_CPU_out !== 16'h0000) begin
      bad++; $display("FAIL clear_err: got %h want 0000", R032h_CPU_out);
    end
    total++;
    if (R024h_CPU_out !== 32'h2) begin
      bad++; $display("FAIL clear_keeps_done: got %h want 00000002", R024h_CPU_out);
    end
  endtask

  task automatic test_reset_mid_send();
    logic [47:0] f;
    start_cmd(16'h0802, 16'h01AA);
    for (int i = 0; i < 20; i++) wait_tick();
    total++;
    if (cmd_pin_out !== 1'b0) begin
      bad++; $display("FAIL mid_send_bit: got %b want 0", cmd_pin_out);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (cmd_pin_out !== 1'b1) begin
      bad++; $display("FAIL abort_cmd_pin: got %b want 1", cmd_pin_out);
    end
    total++;
    if ({R024h_CPU_out, R00eh_CPU_out, R008h_CPU_out, R032h_CPU_out} !== 80'h0) begin
      bad++;
      $display("FAIL abort_outputs: got %h %h %h %h want all 0",
               R024h_CPU_out, R00eh_CPU_out, R008h_CPU_out, R032h_CPU_out);
    end
    reset = 1'b1;
    start_cmd(16'h0000, 16'h0000);
    capture(f);
    total++;
    if (f !== 48'h400000000095) begin
      bad++; $display("FAIL after_abort_frame: got %h want 400000000095", f);
    end
    wait_tick();
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (R024h_CPU_out !== 32'h2) begin
      bad++; $display("FAIL after_abort_status: got %h want 00000002", R024h_CPU_out);
    end
  endtask

  initial begin
    reset      = 1'b0;
    cmd_pin_in = 1'b1;
    R024h_CPU  = 32'h0;
    R00eh_CPU  = 16'h0;
    R008h_CPU  = 16'h0;
    R032h_CPU  = 16'h0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b1;
    test_cmd0();
    test_cmd8_ok();
    test_bad_response();
    test_timeout_busy();
    test_clear();
    test_reset_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
